// File: rtl/acc_ctrl_fsm.sv
// acc_ctrl_fsm: word-by-word read -> datapath -> write transfer controller; ACC_CTRL_TIMEOUT_EN adds a wait timeout.
module acc_ctrl_fsm #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int LEN_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] cfg_src_i,
    input  logic [ADDR_W-1:0] cfg_dst_i,
    input  logic [LEN_W-1:0]  cfg_len_i,
    output logic              data_req_o,
    output logic              data_we_o,
    input  logic              data_gnt_i,
    input  logic              data_rvalid_i,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [DATA_W-1:0] data_wdata_o,
    output logic [3:0]        data_be_o,
    input  logic [DATA_W-1:0] data_rdata_i,
    output logic              dp_in_valid_o,
    output logic [DATA_W-1:0] dp_in_data_o,
    input  logic              dp_out_valid_i,
    input  logic [DATA_W-1:0] dp_out_data_i,
    output logic [3:0]        state_o,
    output logic [3:0]        error_o,
    output logic              done_o
);
    typedef enum logic [3:0] {
        IDLE = 4'h0, RUNNING = 4'h1, RD_REQ = 4'h2, WR_REQ = 4'h3, DONE = 4'h4
    } state_t;
    localparam logic [3:0] E_OKAY = 4'h0, E_CFG = 4'h1, E_OTHERS = 4'h2;

    state_t state, state_n;
    logic [ADDR_W-1:0] src, dst, offset;
    logic [LEN_W-1:0]  len, idx;
    logic [DATA_W-1:0] result;
    logic sent;
    logic timeout;
    logic bad_cfg, last;

    assign offset  = ADDR_W'(idx) << 2;
    assign bad_cfg = cfg_len_i == '0 || cfg_src_i[1:0] != 2'b00 || cfg_dst_i[1:0] != 2'b00;
    assign last    = idx == len - LEN_W'(1);

`ifdef ACC_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt;
    // cycles spent waiting in the current state; restarts whenever the state changes
    always_ff @(posedge clk or posedge rst)
        if (rst) tcnt <= '0;
        else if (state_n != state || !(state inside {RD_REQ, WR_REQ, RUNNING})) tcnt <= '0;
        else tcnt <= tcnt + TW'(1);
    assign timeout = tcnt == TW'(TIMEOUT_CYC);
`else
    assign timeout = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;

    // next-state logic; a timed-out wait abandons the transfer
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_i) state_n = bad_cfg ? DONE : RD_REQ;
            RD_REQ:  if (timeout) state_n = DONE; else if (data_gnt_i) state_n = RUNNING;
            RUNNING: if (timeout) state_n = DONE; else if (sent && dp_out_valid_i) state_n = WR_REQ;
            WR_REQ:  if (timeout) state_n = DONE; else if (data_gnt_i) state_n = last ? DONE : RD_REQ;
            DONE:    if (clear_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign data_req_o   = (state == RD_REQ || state == WR_REQ) && !timeout;
    assign data_we_o    = data_req_o && state == WR_REQ;
    assign data_addr_o  = data_req_o ? (data_we_o ? dst : src) + offset : '0;
    assign data_wdata_o = data_we_o ? result : '0;
    assign data_be_o    = data_req_o ? 4'hF : 4'h0;
    assign state_o      = state;
    assign done_o       = state == DONE;

    // transfer context: latched config, word index, error code, datapath handshake
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            src           <= '0;
            dst           <= '0;
            len           <= '0;
            idx           <= '0;
            result        <= '0;
            sent          <= 1'b0;
            error_o       <= E_OKAY;
            dp_in_valid_o <= 1'b0;
            dp_in_data_o  <= '0;
        end else begin
            dp_in_valid_o <= 1'b0;
            if (state == IDLE && start_i) begin
                src     <= cfg_src_i;
                dst     <= cfg_dst_i;
                len     <= cfg_len_i;
                idx     <= '0;
                error_o <= bad_cfg ? E_CFG : E_OKAY;
            end
            if (timeout) error_o <= E_OTHERS;
            if (state == RUNNING && !sent && data_rvalid_i && !timeout) begin
                dp_in_data_o  <= data_rdata_i;
                dp_in_valid_o <= 1'b1;
                sent          <= 1'b1;
            end
            if (state_n != RUNNING) sent <= 1'b0;
            if (state == RUNNING && state_n == WR_REQ) result <= dp_out_data_i;
            if (state == WR_REQ && state_n == RD_REQ) idx <= idx + LEN_W'(1);
        end
endmodule

// File: tb/tb_acc_ctrl_fsm.sv
// tb_acc_ctrl_fsm: randomized scoreboard bench for acc_ctrl_fsm with memory and datapath responders.
module tb_acc_ctrl_fsm;
    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, clear_i;
    logic [31:0] cfg_src_i, cfg_dst_i;
    logic [15:0] cfg_len_i;
    logic        data_req_o, data_we_o, data_gnt_i;
    logic        data_rvalid_i = 1'b0;
    logic [31:0] data_addr_o, data_wdata_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_rdata_i = '0;
    logic        dp_in_valid_o;
    logic [31:0] dp_in_data_o;
    logic        dp_out_valid_i;
    logic [31:0] dp_out_data_i;
    logic [3:0]  state_o, error_o;
    logic        done_o;

    logic [1:0]  gnt_sel;
    logic        gnt_rand = 1'b1;
    logic        dp_zero, dp_late = 1'b0;
    logic [31:0] dp_late_data = '0;
    int          dp_dly;

    int checks = 0, errors = 0;
    logic [3:0] last_err;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;
    txn_t       txq[$];
    logic [3:0] errq[$];

    acc_ctrl_fsm #(.ADDR_W(32), .DATA_W(32), .LEN_W(16), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .clear_i(clear_i),
        .cfg_src_i(cfg_src_i), .cfg_dst_i(cfg_dst_i), .cfg_len_i(cfg_len_i),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_gnt_i(data_gnt_i),
        .data_rvalid_i(data_rvalid_i), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_be_o(data_be_o), .data_rdata_i(data_rdata_i),
        .dp_in_valid_o(dp_in_valid_o), .dp_in_data_o(dp_in_data_o),
        .dp_out_valid_i(dp_out_valid_i), .dp_out_data_i(dp_out_data_i),
        .state_o(state_o), .error_o(error_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    // grant: random, always, never, or reads only
    assign data_gnt_i = gnt_sel == 2'd0 ? gnt_rand : gnt_sel == 2'd1 ? 1'b1 :
                        gnt_sel == 2'd2 ? 1'b0 : !data_we_o;
    // datapath adds one, either combinationally in the same cycle or after dp_dly cycles
    assign dp_out_valid_i = dp_zero ? dp_in_valid_o : dp_late;
    assign dp_out_data_i  = dp_zero ? dp_in_data_o + 32'd1 : dp_late_data;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // reference model: the whole transfer is expanded into its expected memory traffic
    task automatic model_push(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        if (l == 16'd0 || s[1:0] != 2'b00 || d[1:0] != 2'b00) begin
            errq.push_back(4'h1);
            last_err = 4'h1;
        end else begin
            for (int i = 0; i < int'(l); i++) begin
                txq.push_back('{1'b0, s + 32'(4 * i), 32'h0});
                txq.push_back('{1'b1, d + 32'(4 * i), mem_word(s + 32'(4 * i)) + 32'd1});
            end
            errq.push_back(4'h0);
            last_err = 4'h0;
        end
    endtask

    task automatic drive_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        @(posedge clk); #1;
        cfg_src_i = s;
        cfg_dst_i = d;
        cfg_len_i = l;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        model_push(s, d, l);
        drive_start(s, d, l);
    endtask

    task automatic wait_state(input logic [3:0] s, input string name);
        int n = 0;
        while (state_o != s && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, state_o, s);
    endtask

    task automatic finish_xfer(input string name);
        wait_state(4'h4, {name, "_done"});
        @(posedge clk); #1 clear_i = 1'b1;
        @(posedge clk); #1 clear_i = 1'b0;
        check({name, "_idle"}, state_o, 4'h0);
        check({name, "_err_kept"}, error_o, last_err);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start_i = 1'b0;
        clear_i = 1'b0;
        txq.delete();
        errq.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // memory: read data (or an ignorable write response) one cycle after each grant
    logic        hs_rd, hs_wr;
    logic [31:0] hs_addr;
    initial forever begin
        @(negedge clk);
        hs_rd   = data_req_o && data_gnt_i && !data_we_o;
        hs_wr   = data_req_o && data_gnt_i && data_we_o;
        hs_addr = data_addr_o;
        @(posedge clk); #1;
        data_rvalid_i = hs_rd || hs_wr;
        data_rdata_i  = hs_rd ? mem_word(hs_addr) : $urandom;
        gnt_rand      = $urandom_range(0, 2) != 0;
    end

    // delayed datapath result
    logic [31:0] dp_op;
    initial forever begin
        @(negedge clk);
        if (dp_in_valid_o && !dp_zero) begin
            dp_op = dp_in_data_o;
            repeat (dp_dly) @(posedge clk);
            #1;
            dp_late      = 1'b1;
            dp_late_data = dp_op + 32'd1;
            @(posedge clk); #1;
            dp_late = 1'b0;
        end
    end

    // monitor: pops the scoreboard on every granted transaction and every DONE entry
    logic        p_req = 1'b0, p_gnt = 1'b0, p_we = 1'b0, p_done = 1'b0;
    logic [31:0] p_addr = '0;
    txn_t        e;
    logic [3:0]  ee;
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (data_req_o && data_gnt_i) begin
                if (txq.size() == 0) check("txn_unexpected", {data_we_o, data_addr_o}, 33'h0);
                else begin
                    e = txq.pop_front();
                    check("txn_we", data_we_o, e.we);
                    check("txn_addr", data_addr_o, e.addr);
                    check("txn_be", data_be_o, 4'hF);
                    if (e.we) check("txn_wdata", data_wdata_o, e.data);
                end
            end
            if (p_req && !p_gnt && data_req_o)
                check("req_stable", {data_we_o, data_addr_o}, {p_we, p_addr});
            if (done_o && !p_done) begin
                check("done_txq_empty", txq.size(), 0);
                if (errq.size() == 0) check("done_unexpected", 1, 0);
                else begin
                    ee = errq.pop_front();
                    check("done_error", error_o, ee);
                end
            end
        end
        p_req  = !rst && data_req_o;
        p_gnt  = data_gnt_i;
        p_we   = data_we_o;
        p_addr = data_addr_o;
        p_done = !rst && done_o;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [31:0] rs, rd;
    logic [15:0] rl;
    int          r;
    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        clear_i = 1'b0;
        cfg_src_i = '0;
        cfg_dst_i = '0;
        cfg_len_i = '0;
        gnt_sel = 2'd1;
        dp_zero = 1'b1;
        dp_dly = 1;
        last_err = 4'h0;
        #12;
        check("rst_state", state_o, 4'h0);
        check("rst_req", data_req_o, 1'b0);
        check("rst_addr", data_addr_o, 32'h0);
        check("rst_err", error_o, 4'h0);
        check("rst_done", done_o, 1'b0);
        check("rst_dpv", dp_in_valid_o, 1'b0);

        // start presented as reset releases is accepted on the first edge
        @(negedge clk);
        rst = 1'b0;
        cfg_src_i = 32'h1000;
        cfg_dst_i = 32'h2000;
        cfg_len_i = 16'd3;
        start_i = 1'b1;
        model_push(32'h1000, 32'h2000, 16'd3);
        @(posedge clk); #1 start_i = 1'b0;
        check("start_after_rst", state_o, 4'h2);
        finish_xfer("basic");

        start_xfer(32'h1000, 32'h2000, 16'd0);
        check("len0_state", state_o, 4'h4);
        finish_xfer("len0");
        start_xfer(32'h1002, 32'h2000, 16'd3);
        check("src_mis_state", state_o, 4'h4);
        finish_xfer("src_mis");
        start_xfer(32'h1000, 32'h2001, 16'd2);
        finish_xfer("dst_mis");

        // grant held off five cycles, then a stray start while RUNNING
        gnt_sel = 2'd2;
        dp_zero = 1'b0;
        dp_dly = 2;
        start_xfer(32'h3000, 32'h4000, 16'd2);
        repeat (5) @(negedge clk);
        check("gnt_wait_req", data_req_o, 1'b1);
        @(posedge clk); #1 gnt_sel = 2'd1;
        wait_state(4'h1, "rd_to_run");
        @(posedge clk); #1;
        cfg_len_i = 16'd0;
        start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        finish_xfer("stray_start");

        // asynchronous reset while a write request is pending
        gnt_sel = 2'd3;
        dp_zero = 1'b1;
        start_xfer(32'h5000, 32'h6000, 16'd2);
        wait_state(4'h3, "wr_reached");
        check("wr_req_high", data_req_o, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_req", data_req_o, 1'b0);
        check("arst_state", state_o, 4'h0);
        check("arst_err", error_o, 4'h0);
        txq.delete();
        errq.delete();
        @(posedge clk); #1 rst = 1'b0;
        gnt_sel = 2'd0;
        start_xfer(32'h5000, 32'h6000, 16'd2);
        finish_xfer("after_arst");

        // start and clear together in DONE: clear wins
        start_xfer(32'h7000, 32'h8000, 16'd1);
        wait_state(4'h4, "pair_done");
        @(posedge clk); #1;
        cfg_src_i = 32'h7100;
        cfg_len_i = 16'd2;
        start_i = 1'b1;
        clear_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        clear_i = 1'b0;
        check("clear_wins", state_o, 4'h0);
        repeat (3) @(negedge clk);
        check("stay_idle", state_o, 4'h0);
        start_xfer(32'h7200, 32'h8200, 16'd2);
        check("start_to_rd", state_o, 4'h2);
        finish_xfer("post_pair");

        // grant never arrives
        gnt_sel = 2'd2;
        drive_start(32'h9000, 32'hA000, 16'd2);
`ifdef ACC_CTRL_TIMEOUT_EN
        errq.push_back(4'h2);
        last_err = 4'h2;
        finish_xfer("timeout");
`else
        repeat (40) @(negedge clk);
        check("no_timeout_state", state_o, 4'h2);
        check("no_timeout_req", data_req_o, 1'b1);
        check("no_timeout_err", error_o, 4'h0);
        do_reset();
`endif
        gnt_sel = 2'd0;

        for (int k = 0; k < 25; k++) begin
            dp_zero = 1'($urandom_range(0, 1));
            dp_dly  = $urandom_range(1, 3);
            r  = $urandom_range(0, 9);
            rs = $urandom;
            rd = $urandom;
            rs[1:0] = 2'b00;
            rd[1:0] = 2'b00;
            rl = 16'($urandom_range(1, 6));
            if (r == 0) rl = 16'd0;
            if (r == 1) rs[0] = 1'b1;
            if (r == 2) rd[1] = 1'b1;
            if (r == 3) rs = 32'hFFFF_FFF8;
            if (r == 4) rd = 32'hFFFF_FFFC;
            start_xfer(rs, rd, rl);
            finish_xfer("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/acc_ctrl_fsm.md
ACC_CTRL_FSM -- requirements
Module: acc_ctrl_fsm

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter LEN_W, default 16, transfer length counter width.
REQ-004 Parameter TIMEOUT_CYC, default 1024, grant/response wait limit in cycles (used only with the timeout feature).
REQ-005 clk  in  1  single clock, all logic rising-edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start_i  in  1  start pulse; cfg_*_i sampled in the same cycle.
REQ-008 clear_i  in  1  acknowledge done; returns FSM to idle.
REQ-009 cfg_src_i / cfg_dst_i  in  ADDR_W each  source/destination byte base addresses.
REQ-010 cfg_len_i  in  LEN_W  number of words to process.
REQ-011 data_req_o, data_we_o  out  1 each; data_gnt_i, data_rvalid_i  in  1 each  shared memory port handshake.
REQ-012 data_addr_o  out  ADDR_W; data_wdata_o  out  DATA_W; data_be_o  out  4; data_rdata_i  in  DATA_W.
REQ-013 dp_in_valid_o  out  1, dp_in_data_o  out  DATA_W  operand to datapath; dp_out_valid_i  in  1, dp_out_data_i  in  DATA_W  datapath result.
REQ-014 state_o  out  4  current state, encoding IDLE=0x0, RUNNING=0x1, RD_REQ=0x2, WR_REQ=0x3, DONE=0x4.
REQ-015 error_o  out  4  OKAY=0x0, INVALID_CFG=0x1, OTHERS=0x2; done_o  out  1  high while in DONE.

Function
REQ-016 IDLE: start_i=1 latches cfg; cfg_len_i=0 or cfg_src_i/cfg_dst_i[1:0]!=0 -> DONE with error INVALID_CFG, no memory access; else error=OKAY, word index=0 -> RD_REQ.
REQ-017 RD_REQ: data_req_o=1, data_we_o=0, data_addr_o=src+4*index, data_be_o=4'hF; held stable until data_gnt_i=1, then -> RUNNING in the next cycle.
REQ-018 RUNNING: on data_rvalid_i=1, drive dp_in_valid_o=1 for exactly one cycle with dp_in_data_o=data_rdata_i registered; then wait for dp_out_valid_i=1, capture dp_out_data_i, -> WR_REQ.
REQ-019 dp_out_valid_i arriving in the same cycle as dp_in_valid_o SHALL be accepted.
REQ-020 WR_REQ: data_req_o=1, data_we_o=1, data_addr_o=dst+4*index, data_wdata_o=captured result, data_be_o=4'hF; on data_gnt_i: index=len-1 -> DONE, else index+1 -> RD_REQ.
REQ-021 Address arithmetic SHALL wrap modulo 2^ADDR_W; index is LEN_W bits and never exceeds len-1.
REQ-022 DONE: done_o=1, error_o held; clear_i=1 -> IDLE, error_o retained until next accepted start.
REQ-023 start_i outside IDLE SHALL be ignored; start_i and clear_i together in DONE: clear wins, start ignored.
REQ-024 At most one memory transaction outstanding; data_req_o low in IDLE, RUNNING, DONE.
REQ-025 Write response (data_rvalid_i after a write grant) SHALL be ignored.

Reset
REQ-026 rst=1 SHALL asynchronously force state IDLE, index 0, error OKAY, all outputs 0, from any state, including mid-transaction.
REQ-027 After rst deassertion the FSM SHALL accept start_i in the first clock edge.

Configuration
REQ-028 Macro ACC_CTRL_TIMEOUT_EN defined: a counter SHALL count cycles spent waiting in RD_REQ, WR_REQ (grant) or RUNNING (rvalid/dp_out_valid); reaching TIMEOUT_CYC -> DONE with error OTHERS, data_req_o dropped in that cycle; counter clears on every state change.
REQ-029 Macro undefined: no counter logic, waits are unbounded, error OTHERS never produced.

Verification
REQ-030 Reset, then start with src=0x1000, dst=0x2000, len=3, zero-wait memory, datapath = +1 -> reads 0x1000/0x1004/0x1008, writes rdata+1 to 0x2000/0x2004/0x2008, DONE, error 0x0.
REQ-031 start with len=0, then separately src=0x1002 -> DONE within 1 cycle, error 0x1, no data_req_o.
REQ-032 Grant delayed 5 cycles in RD_REQ -> addr/we stable 6 cycles, single read issued; start pulse during RUNNING ignored.
REQ-033 rst asserted during WR_REQ with data_req_o high -> data_req_o and state_o 0 immediately (asynchronous), next start runs cleanly.
REQ-034 In DONE, start_i and clear_i both 1 -> IDLE, no new transfer; next start_i -> RD_REQ.
REQ-035 With ACC_CTRL_TIMEOUT_EN, TIMEOUT_CYC=16, data_gnt_i held low -> DONE at wait cycle 16, error 0x2; without macro -> remains in RD_REQ indefinitely.
